// File: rtl/ex_hazard_unit.sv
// ex_hazard_unit: EX-stage operand forwarding, load-use stall and mul/div sequencing (optional macro LOAD_USE_STALL_EN)
module ex_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int MD_LAT  = 4,
  parameter int SEL_W   = $clog2(NUM_FWD+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      e_valid,
  input  logic [REG_AW-1:0]         e_rs1,
  input  logic [REG_AW-1:0]         e_rs2,
  input  logic [REG_AW-1:0]         e_rd,
  input  logic                      e_use_rs1,
  input  logic                      e_use_rs2,
  input  logic                      e_is_md,
  input  logic                      e_flush,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic [SEL_W-1:0]          rs1_sel,
  output logic [SEL_W-1:0]          rs2_sel,
  output logic                      stall_e,
  output logic                      md_start,
  output logic                      md_busy,
  output logic                      md_done,
  output logic [REG_AW-1:0]         md_rd
);
  localparam int CW = $clog2(MD_LAT);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [NUM_FWD-1:0] m1, m2;
  logic lu_hz, md_req, unused_load;
  for (genvar k = 0; k < NUM_FWD; k++) begin : g_m
    assign m1[k] = e_use_rs1 & fwd_we[k] & (fwd_rd[k*REG_AW +: REG_AW] == e_rs1) & (e_rs1 != '0);
    assign m2[k] = e_use_rs2 & fwd_we[k] & (fwd_rd[k*REG_AW +: REG_AW] == e_rs2) & (e_rs2 != '0);
  end
  // youngest matching producer wins: scan from the oldest stage down so the lowest index overrides
  always_comb begin
    rs1_sel = '0;
    rs2_sel = '0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      rs1_sel = m1[k] ? SEL_W'(k+1) : rs1_sel;
      rs2_sel = m2[k] ? SEL_W'(k+1) : rs2_sel;
    end
  end
`ifdef LOAD_USE_STALL_EN
  assign lu_hz = e_valid & (m1[0] | m2[0]) & fwd_is_load[0];
`else
  assign lu_hz = 1'b0;
`endif
  assign unused_load = ^fwd_is_load;
  assign md_req = e_valid & e_is_md & !lu_hz & !e_flush;
  // state, countdown and latched destination; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      md_rd <= '0;
    end else begin
      state <= state_nx;
      cnt   <= md_start ? CW'(MD_LAT-1) : (state == BUSY) ? (e_flush ? '0 : cnt - CW'(1)) : cnt;
      if (md_start) md_rd <= e_rd;
    end
  end
  // next state: flush in BUSY aborts, last count moves to DONE, DONE lasts one cycle
  always_comb begin
    state_nx = (state == IDLE) ? (md_req ? BUSY : IDLE) :
               (state == BUSY) ? (e_flush ? IDLE : (cnt == CW'(1)) ? DONE : BUSY) : IDLE;
  end
  // outputs: EX is held while a load-use hazard or the mul/div is pending, released in DONE
  always_comb begin
    md_start = (state == IDLE) & md_req;
    md_busy  = (state == BUSY);
    md_done  = (state == DONE);
    stall_e  = ((state == IDLE) & !e_flush & lu_hz) | md_start | ((state == BUSY) & !e_flush);
  end
endmodule

// File: tb/tb_ex_hazard_unit.sv
// tb_ex_hazard_unit: table vectors, hand sequences and random stimulus against a reference model
module tb_ex_hazard_unit;
  localparam int AW = 5, NF = 3, LAT = 4, SW = $clog2(NF+1);
  logic clk = 0, rst = 0;
  logic e_valid = 0, e_use_rs1 = 0, e_use_rs2 = 0, e_is_md = 0, e_flush = 0;
  logic [AW-1:0] e_rs1 = 0, e_rs2 = 0, e_rd = 0;
  logic [NF*AW-1:0] fwd_rd = 0;
  logic [NF-1:0] fwd_we = 0, fwd_is_load = 0;
  logic [SW-1:0] rs1_sel, rs2_sel;
  logic stall_e, md_start, md_busy, md_done;
  logic [AW-1:0] md_rd;
  int n_tests = 0, n_fail = 0;
  int age = 0;
  logic [AW-1:0] m_rd = 0;

  always #5 clk = ~clk;

  ex_hazard_unit #(.REG_AW(AW), .NUM_FWD(NF), .MD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_use_rs1(e_use_rs1), .e_use_rs2(e_use_rs2), .e_is_md(e_is_md), .e_flush(e_flush),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_is_load(fwd_is_load),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .stall_e(stall_e), .md_start(md_start),
    .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd)
  );

  typedef struct {
    logic [AW-1:0] rs1, rs2;
    logic u1, u2, v;
    logic [NF-1:0] we, ld;
    logic [AW-1:0] r0, r1, r2;
    int s1, s2;
    bit lu;
  } vec_t;
  vec_t tv[11];

  task automatic chk(string n, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int fsel(logic use_x, logic [AW-1:0] rs, logic [NF-1:0] we, logic [NF*AW-1:0] rd);
    for (int k = 0; k < NF; k++)
      if (use_x && we[k] && rd[k*AW +: AW] == rs && rs != 0) return k + 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    e_valid = 0; e_use_rs1 = 0; e_use_rs2 = 0; e_is_md = 0; e_flush = 0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; fwd_rd = 0; fwd_we = 0; fwd_is_load = 0;
  endtask

  task automatic cycle();
    int s1, s2;
    bit idle, busy, done, lu, st, stall;
    #2;
    s1 = fsel(e_use_rs1, e_rs1, fwd_we, fwd_rd);
    s2 = fsel(e_use_rs2, e_rs2, fwd_we, fwd_rd);
    idle = (age == 0);
    busy = (age >= 1 && age < LAT);
    done = (age == LAT);
`ifdef LOAD_USE_STALL_EN
    lu = e_valid && fwd_is_load[0] && (s1 == 1 || s2 == 1);
`else
    lu = 0;
`endif
    st = idle && e_valid && e_is_md && !lu && !e_flush;
    stall = (idle && !e_flush && lu) || st || (busy && !e_flush);
    chk("rs1_sel", rs1_sel, s1);
    chk("rs2_sel", rs2_sel, s2);
    chk("stall_e", stall_e, stall);
    chk("md_start", md_start, st);
    chk("md_busy", md_busy, busy);
    chk("md_done", md_done, done);
    chk("md_rd", md_rd, m_rd);
    @(posedge clk);
    if (st) begin age = 1; m_rd = e_rd; end
    else if (busy && e_flush) age = 0;
    else if (done) age = 0;
    else if (busy) age++;
    @(negedge clk);
  endtask

  task automatic start_md(logic [AW-1:0] rd);
    idle_inputs();
    e_valid = 1; e_is_md = 1; e_rd = rd;
  endtask

  initial begin
    tv[0]  = '{5'd5, 5'd0,  1, 0, 1, 3'b111, 3'b000, 5'd5,  5'd3, 5'd5, 1, 0, 0};
    tv[1]  = '{5'd5, 5'd0,  1, 0, 1, 3'b110, 3'b000, 5'd5,  5'd3, 5'd5, 3, 0, 0};
    tv[2]  = '{5'd1, 5'd0,  0, 1, 1, 3'b001, 3'b000, 5'd0,  5'd0, 5'd0, 0, 0, 0};
    tv[3]  = '{5'd7, 5'd0,  1, 0, 1, 3'b001, 3'b001, 5'd7,  5'd0, 5'd0, 1, 0, 1};
    tv[4]  = '{5'd7, 5'd0,  1, 0, 1, 3'b010, 3'b010, 5'd0,  5'd7, 5'd0, 2, 0, 0};
    tv[5]  = '{5'd7, 5'd0,  0, 0, 1, 3'b001, 3'b001, 5'd7,  5'd0, 5'd0, 0, 0, 0};
    tv[6]  = '{5'd9, 5'd9,  1, 1, 1, 3'b110, 3'b000, 5'd9,  5'd9, 5'd9, 2, 2, 0};
    tv[7]  = '{5'd3, 5'd12, 1, 1, 1, 3'b101, 3'b001, 5'd12, 5'd0, 5'd3, 3, 1, 1};
    tv[8]  = '{5'd7, 5'd0,  1, 0, 1, 3'b000, 3'b001, 5'd7,  5'd0, 5'd0, 0, 0, 0};
    tv[9]  = '{5'd7, 5'd0,  1, 0, 0, 3'b001, 3'b001, 5'd7,  5'd0, 5'd0, 1, 0, 0};
    tv[10] = '{5'd4, 5'd6,  1, 1, 1, 3'b111, 3'b000, 5'd1,  5'd2, 5'd3, 0, 0, 0};

    idle_inputs();
    repeat (2) @(negedge clk);
    #1 chk("rst_md_busy", md_busy, 0);
    chk("rst_md_rd", md_rd, 0);
    rst = 1;
    #1 chk("rst_md_done", md_done, 0);
    chk("rst_stall", stall_e, 0);
    chk("rst_md_start", md_start, 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      e_rs1 = tv[i].rs1; e_rs2 = tv[i].rs2; e_use_rs1 = tv[i].u1; e_use_rs2 = tv[i].u2;
      e_valid = tv[i].v; fwd_we = tv[i].we; fwd_is_load = tv[i].ld;
      fwd_rd = {tv[i].r2, tv[i].r1, tv[i].r0};
      #1 chk($sformatf("vec%0d_rs1_sel", i), rs1_sel, tv[i].s1);
      chk($sformatf("vec%0d_rs2_sel", i), rs2_sel, tv[i].s2);
`ifdef LOAD_USE_STALL_EN
      chk($sformatf("vec%0d_stall", i), stall_e, tv[i].lu);
`else
      chk($sformatf("vec%0d_stall", i), stall_e, 0);
`endif
      cycle();
    end

    start_md(5'd9);
    for (int j = 0; j <= 5; j++) begin
      if (j == 5) idle_inputs();
      #1 chk($sformatf("seq_start_T%0d", j), md_start, j == 0);
      chk($sformatf("seq_busy_T%0d", j), md_busy, j >= 1 && j <= 3);
      chk($sformatf("seq_done_T%0d", j), md_done, j == 4);
      chk($sformatf("seq_stall_T%0d", j), stall_e, j <= 3);
      if (j >= 1) chk($sformatf("seq_rd_T%0d", j), md_rd, 9);
      cycle();
    end

    start_md(5'd14);
    cycle();
    cycle();
    e_flush = 1;
    #1 chk("flush_stall_T2", stall_e, 0);
    cycle();
    idle_inputs();
    #1 chk("flush_idle_T3", md_busy, 0);
    for (int j = 0; j < LAT + 2; j++) begin
      #1 chk("flush_no_done", md_done, 0);
      cycle();
    end

    start_md(5'd21);
    cycle();
    cycle();
    #1 rst = 0;
    idle_inputs();
    #1 chk("arst_busy", md_busy, 0);
    chk("arst_rd", md_rd, 0);
    age = 0; m_rd = 0;
    @(negedge clk);
    rst = 1;
    for (int j = 0; j < LAT + 2; j++) begin
      #1 chk("arst_no_done", md_done, 0);
      cycle();
    end
    start_md(5'd11);
    for (int j = 0; j <= LAT; j++) begin
      #1 chk($sformatf("restart_done_T%0d", j), md_done, j == LAT);
      cycle();
    end
    idle_inputs();
    #1 chk("restart_rd", md_rd, 11);
    cycle();

    for (int i = 0; i < 400; i++) begin
      e_valid = ($urandom_range(0, 7) != 0);
      e_rs1 = AW'($urandom_range(0, 7));
      e_rs2 = AW'($urandom_range(0, 7));
      e_rd = AW'($urandom);
      e_use_rs1 = 1'($urandom);
      e_use_rs2 = 1'($urandom);
      e_is_md = ($urandom_range(0, 3) == 0);
      e_flush = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NF; k++) fwd_rd[k*AW +: AW] = AW'($urandom_range(0, 7));
      fwd_we = NF'($urandom);
      fwd_is_load = (age == 0) ? NF'($urandom) : '0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
